midi_voice_allocator: RTL and testbench

- Schedules decoded MIDI note events onto a fixed pool of NUM_VOICES synth voices inside the MIDI player.
- Accepts one note-on or note-off per handshake and drives per-voice gate, note, velocity and trigger signals to the voice oscillators and envelopes.
- On note-on, allocation priority is: a voice already playing the same note, then the lowest-index free voice, then the oldest voice (steal).
- Sits between the MIDI byte parser and the voice bank; owns all voice-assignment state.

---
 rtl/midi_voice_allocator.sv | 165 ++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_voice_allocator.sv
// Purpose: assigns MIDI note-on/off events to a fixed pool of synth voices (match, free, then steal oldest).
// Latency: outputs update NUM_VOICES+1 edges after the accepting edge (one SCAN cycle per voice plus COMMIT).
// Backpressure: ev_ready is high only in IDLE with panic low; one event is in flight at a time.
module midi_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_BITS   = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_note_on,
  input  logic [6:0]              ev_note,
  input  logic [6:0]              ev_vel,
  input  logic                    panic,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    steal
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;

  logic [1:0]          state;
  logic [IDX_W-1:0]    idx;

  // Event captured at the handshake; lat_on already folds velocity-0 note-on into note-off.
  logic [6:0]          lat_note;
  logic [6:0]          lat_vel;
  logic                lat_on;

  // Scan candidates, rebuilt for every event.
  logic                match_vld;
  logic [IDX_W-1:0]    match_idx;
  logic                free_vld;
  logic [IDX_W-1:0]    free_idx;
  logic [IDX_W-1:0]    old_idx;
  logic [AGE_BITS-1:0] old_age;

  logic [6:0]          note_r [NUM_VOICES];
  logic [6:0]          vel_r  [NUM_VOICES];
  logic [AGE_BITS-1:0] age_r  [NUM_VOICES];

  logic [IDX_W-1:0]    target;

  assign ev_ready = (state == IDLE) && !panic;

  // Note-on target: an already-held copy of the note, else the lowest free voice, else the oldest.
  always_comb begin
    target = old_idx;
    if (match_vld) begin
      target = match_idx;
    end else if (free_vld) begin
      target = free_idx;
    end
  end

  // Allocation FSM and all per-voice state; panic overrides everything except reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      lat_note   <= '0;
      lat_vel    <= '0;
      lat_on     <= 1'b0;
      match_vld  <= 1'b0;
      match_idx  <= '0;
      free_vld   <= 1'b0;
      free_idx   <= '0;
      old_idx    <= '0;
      old_age    <= '0;
      voice_gate <= '0;
      voice_trig <= '0;
      steal      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= '0;
        vel_r[i]  <= '0;
        age_r[i]  <= '0;
      end
    end else begin
      voice_trig <= '0;
      steal      <= 1'b0;
      if (panic) begin
        // Notes and velocities are kept so the envelopes can release cleanly.
        state      <= IDLE;
        voice_gate <= '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
          age_r[i] <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            if (ev_valid) begin
              lat_note  <= ev_note;
              lat_vel   <= ev_vel;
              lat_on    <= ev_note_on && (ev_vel != 7'd0);
              match_vld <= 1'b0;
              match_idx <= '0;
              free_vld  <= 1'b0;
              free_idx  <= '0;
              old_idx   <= '0;
              old_age   <= '0;
              idx       <= '0;
              state     <= SCAN;
            end
          end
          SCAN: begin
            if (!match_vld && voice_gate[idx] && (note_r[idx] == lat_note)) begin
              match_vld <= 1'b1;
              match_idx <= idx;
            end
            if (!free_vld && !voice_gate[idx]) begin
              free_vld <= 1'b1;
              free_idx <= idx;
            end
            // Strict compare while scanning upward keeps ties on the lowest index.
            if (age_r[idx] > old_age) begin
              old_age <= age_r[idx];
              old_idx <= idx;
            end
            if (idx == LAST_IDX) begin
              state <= COMMIT;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          COMMIT: begin
            state <= IDLE;
            if (lat_on) begin
              voice_gate[target] <= 1'b1;
              note_r[target]     <= lat_note;
              vel_r[target]      <= lat_vel;
              age_r[target]      <= '0;
              voice_trig[target] <= 1'b1;
              steal              <= !match_vld && !free_vld && voice_gate[target];
              for (int i = 0; i < NUM_VOICES; i++) begin
                if ((IDX_W'(i) != target) && (age_r[i] != AGE_MAX)) begin
                  age_r[i] <= age_r[i] + AGE_BITS'(1);
                end
              end
            end else if (match_vld) begin
              voice_gate[match_idx] <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Flatten per-voice note and velocity onto the packed output buses.
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign voice_note[7*g +: 7] = note_r[g];
    assign voice_vel[7*g +: 7]  = vel_r[g];
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
`timescale 1ns/1ps
module tb_midi_voice_allocator;

  logic        clk;
  logic        reset_n;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_note_on;
  logic [6:0]  ev_note;
  logic [6:0]  ev_vel;
  logic        panic;
  logic [3:0]  voice_gate;
  logic [27:0] voice_note;
  logic [27:0] voice_vel;
  logic [3:0]  voice_trig;
  logic        steal;

  int vectors;
  int errors;

  midi_voice_allocator #(.NUM_VOICES(4), .AGE_BITS(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_note_on (ev_note_on),
    .ev_note    (ev_note),
    .ev_vel     (ev_vel),
    .panic      (panic),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_vel  (voice_vel),
    .voice_trig (voice_trig),
    .steal      (steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    panic    = 1'b0;
    ev_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Presents one event, waits for the handshake, and returns one cycle after COMMIT.
  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel);
    int cnt;
    cnt        = 0;
    ev_valid   = 1'b1;
    ev_note_on = on;
    ev_note    = note;
    ev_vel     = vel;
    while (!ev_ready && cnt < 50) begin
      tick();
      cnt++;
    end
    if (cnt >= 50) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: ev_ready=%0b after %0d cycles, required 1", ev_ready, cnt);
    end
    tick();
    ev_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    vectors++; if (voice_gate !== 4'b0000) begin errors++; $display("FAIL reset_gate: got %b want 0000", voice_gate); end
    vectors++; if (voice_note !== 28'd0) begin errors++; $display("FAIL reset_note: got %h want 0", voice_note); end
    vectors++; if (voice_vel !== 28'd0) begin errors++; $display("FAIL reset_vel: got %h want 0", voice_vel); end
    vectors++; if (voice_trig !== 4'b0000 || steal !== 1'b0) begin errors++; $display("FAIL reset_pulses: trig=%b steal=%b want 0000/0", voice_trig, steal); end
    vectors++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ev_ready); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    do_reset();
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd60; ev_vel = 7'd100;
    vectors++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL lat_ready_idle: got %b want 1", ev_ready); end
    tick();
    ev_valid = 1'b0;
    vectors++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_c1: got %b want 0", ev_ready); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      vectors++;
      if (ev_ready !== 1'b0 || voice_gate !== 4'b0000) begin
        errors++; $display("FAIL lat_busy_c%0d: ready=%b gate=%b want 0/0000", k, ev_ready, voice_gate);
      end
    end
    tick();
    vectors++; if (voice_gate !== 4'b0001) begin errors++; $display("FAIL lat_gate: got %b want 0001", voice_gate); end
    vectors++; if (voice_note[6:0] !== 7'd60) begin errors++; $display("FAIL lat_note: got %0d want 60", voice_note[6:0]); end
    vectors++; if (voice_vel[6:0] !== 7'd100) begin errors++; $display("FAIL lat_vel: got %0d want 100", voice_vel[6:0]); end
    vectors++; if (voice_trig !== 4'b0001 || steal !== 1'b0) begin errors++; $display("FAIL lat_trig: trig=%b steal=%b want 0001/0", voice_trig, steal); end
    vectors++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL lat_ready_back: got %b want 1", ev_ready); end
    tick();
    vectors++; if (voice_trig !== 4'b0000 || voice_gate !== 4'b0001) begin errors++; $display("FAIL lat_trig_end: trig=%b gate=%b want 0000/0001", voice_trig, voice_gate); end
  endtask

  task automatic test_steal();
    do_reset();
    send(1'b1, 7'd60, 7'd100);
    send(1'b1, 7'd62, 7'd100);
    send(1'b1, 7'd64, 7'd100);
    send(1'b1, 7'd67, 7'd100);
    vectors++; if (voice_gate !== 4'b1111 || steal !== 1'b0) begin errors++; $display("FAIL fill_gate: gate=%b steal=%b want 1111/0", voice_gate, steal); end
    vectors++; if (voice_note !== {7'd67, 7'd64, 7'd62, 7'd60}) begin errors++; $display("FAIL fill_notes: got %h", voice_note); end
    send(1'b1, 7'd69, 7'd100);
    vectors++; if (voice_note !== {7'd67, 7'd64, 7'd62, 7'd69}) begin errors++; $display("FAIL steal_notes: got %h want v0=69", voice_note); end
    vectors++; if (steal !== 1'b1 || voice_trig !== 4'b0001) begin errors++; $display("FAIL steal_pulse: steal=%b trig=%b want 1/0001", steal, voice_trig); end
    vectors++; if (voice_gate !== 4'b1111) begin errors++; $display("FAIL steal_gate: got %b want 1111", voice_gate); end
    tick();
    vectors++; if (steal !== 1'b0) begin errors++; $display("FAIL steal_end: got %b want 0", steal); end
    // Voice 1 (holding 62) is now the oldest.
    send(1'b1, 7'd70, 7'd90);
    vectors++; if (voice_note !== {7'd67, 7'd64, 7'd70, 7'd69} || voice_trig !== 4'b0010 || steal !== 1'b1) begin
      errors++; $display("FAIL steal2: notes=%h trig=%b steal=%b want v1=70/0010/1", voice_note, voice_trig, steal);
    end
  endtask

  task automatic test_note_off();
    do_reset();
    send(1'b1, 7'd62, 7'd100);
    send(1'b1, 7'd65, 7'd100);
    send(1'b0, 7'd62, 7'd64);
    vectors++; if (voice_gate !== 4'b0010) begin errors++; $display("FAIL off_gate: got %b want 0010", voice_gate); end
    vectors++; if (voice_note[6:0] !== 7'd62 || voice_vel[6:0] !== 7'd100) begin errors++; $display("FAIL off_hold: note=%0d vel=%0d want 62/100", voice_note[6:0], voice_vel[6:0]); end
    vectors++; if (voice_trig !== 4'b0000) begin errors++; $display("FAIL off_trig: got %b want 0000", voice_trig); end
    send(1'b0, 7'd55, 7'd64);
    vectors++; if (voice_gate !== 4'b0010 || voice_note !== {7'd0, 7'd0, 7'd65, 7'd62}) begin
      errors++; $display("FAIL off_unheld: gate=%b notes=%h want 0010 unchanged", voice_gate, voice_note);
    end
    send(1'b1, 7'd66, 7'd50);
    vectors++; if (voice_gate !== 4'b0011 || voice_note[6:0] !== 7'd66 || voice_trig !== 4'b0001) begin
      errors++; $display("FAIL free_reuse: gate=%b note0=%0d trig=%b want 0011/66/0001", voice_gate, voice_note[6:0], voice_trig);
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    send(1'b1, 7'd60, 7'd100);
    send(1'b1, 7'd60, 7'd40);
    vectors++; if (voice_gate !== 4'b0001) begin errors++; $display("FAIL retrig_gate: got %b want 0001", voice_gate); end
    vectors++; if (voice_vel[6:0] !== 7'd40) begin errors++; $display("FAIL retrig_vel: got %0d want 40", voice_vel[6:0]); end
    vectors++; if (voice_trig !== 4'b0001 || steal !== 1'b0) begin errors++; $display("FAIL retrig_pulse: trig=%b steal=%b want 0001/0", voice_trig, steal); end
  endtask

  task automatic test_vel0();
    do_reset();
    send(1'b1, 7'd50, 7'd100);
    send(1'b1, 7'd64, 7'd100);
    send(1'b1, 7'd64, 7'd0);
    vectors++; if (voice_gate !== 4'b0001 || voice_trig !== 4'b0000) begin
      errors++; $display("FAIL vel0_off: gate=%b trig=%b want 0001/0000", voice_gate, voice_trig);
    end
    vectors++; if (voice_note[13:7] !== 7'd64) begin errors++; $display("FAIL vel0_hold: got %0d want 64", voice_note[13:7]); end
  endtask

  task automatic test_panic();
    do_reset();
    send(1'b1, 7'd60, 7'd100);
    send(1'b1, 7'd62, 7'd100);
    send(1'b1, 7'd64, 7'd100);
    send(1'b1, 7'd67, 7'd100);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd72; ev_vel = 7'd90;
    tick();
    ev_valid = 1'b0;
    tick();
    panic = 1'b1;
    #1;
    vectors++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL panic_ready: got %b want 0", ev_ready); end
    tick();
    vectors++; if (voice_gate !== 4'b0000 || ev_ready !== 1'b0) begin errors++; $display("FAIL panic_gate: gate=%b ready=%b want 0000/0", voice_gate, ev_ready); end
    panic = 1'b0;
    #1;
    vectors++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL panic_release: got %b want 1", ev_ready); end
    repeat (8) tick();
    vectors++; if (voice_gate !== 4'b0000 || voice_note !== {7'd67, 7'd64, 7'd62, 7'd60}) begin
      errors++; $display("FAIL panic_discard: gate=%b notes=%h want 0000, no 72", voice_gate, voice_note);
    end
    send(1'b1, 7'd72, 7'd90);
    vectors++; if (voice_gate !== 4'b0001 || voice_note[6:0] !== 7'd72 || steal !== 1'b0) begin
      errors++; $display("FAIL panic_after: gate=%b note0=%0d steal=%b want 0001/72/0", voice_gate, voice_note[6:0], steal);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    send(1'b1, 7'd60, 7'd100);
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd61; ev_vel = 7'd80;
    tick();
    ev_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    vectors++; if (voice_gate !== 4'b0000 || voice_note !== 28'd0 || ev_ready !== 1'b1) begin
      errors++; $display("FAIL abort_reset: gate=%b notes=%h ready=%b want 0000/0/1", voice_gate, voice_note, ev_ready);
    end
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    vectors++; if (voice_gate !== 4'b0000 || voice_note !== 28'd0) begin
      errors++; $display("FAIL abort_quiet: gate=%b notes=%h want 0000/0", voice_gate, voice_note);
    end
  endtask

  initial begin
    vectors    = 0;
    errors     = 0;
    reset_n    = 1'b0;
    panic      = 1'b0;
    ev_valid   = 1'b0;
    ev_note_on = 1'b0;
    ev_note    = '0;
    ev_vel     = '0;
    tick();
    test_reset();
    test_latency();
    test_steal();
    test_note_off();
    test_retrigger();
    test_vel0();
    test_panic();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
